// File: rtl/mandelbrot_frame_ctrl_if.sv
// Pixel result stream from the frame controller's FIFO to the readout side.
interface mandelbrot_frame_ctrl_if;
   logic       pix_valid;
   logic [3:0] pix_data;
   logic       pix_last;
   logic       pix_ready;

   modport master (output pix_valid, output pix_data, output pix_last, input pix_ready);
   modport slave  (input pix_valid, input pix_data, input pix_last, output pix_ready);
endinterface

// File: rtl/mandelbrot_frame_ctrl.sv
// Frame controller for the mandelbrot pixel engine: issues one run pulse per
// pixel, captures results into a small FIFO, and updates engine scaling and
// C offsets at every frame boundary (optionally zooming in automatically).
//
// state         | meaning
// --------------+----------------------------------------------------------
// ST_IDLE       | paused or waiting for FIFO space; reloads base config if
//               | the engine reports a finished frame
// ST_ISSUE      | eng_run high for one cycle
// ST_WAIT_START | waiting for the engine to report busy
// ST_WAIT_DONE  | engine busy; result pushed on the first idle cycle
// ST_FRAME_END  | frame counter bump and zoom step, then back to IDLE
module mandelbrot_frame_ctrl #(
   parameter int BITWIDTH   = 10,
   parameter int FIFO_DEPTH = 8,
   parameter int FRAMEWIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  auto_zoom,
   input  logic [6:0]            base_scaling,
   input  logic [BITWIDTH-1:0]   base_cr,
   input  logic [BITWIDTH-1:0]   base_ci,
   input  logic [BITWIDTH-1:0]   cr_step,
   input  logic [BITWIDTH-1:0]   ci_step,
   output logic                  eng_run,
   input  logic                  eng_running,
   input  logic                  eng_finished,
   input  logic [3:0]            eng_ctr_out,
   output logic [6:0]            eng_scaling,
   output logic [BITWIDTH-1:0]   eng_cr_offset,
   output logic [BITWIDTH-1:0]   eng_ci_offset,
   mandelbrot_frame_ctrl_if.master pix,
   output logic [FRAMEWIDTH-1:0] frame_count
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_START,
      ST_WAIT_DONE,
      ST_FRAME_END
   } state_t;

   state_t state_q, state_d;

   logic [6:0]            eng_scaling_q, eng_scaling_d;
   logic [BITWIDTH-1:0]   eng_cr_offset_q, eng_cr_offset_d;
   logic [BITWIDTH-1:0]   eng_ci_offset_q, eng_ci_offset_d;
   logic [FRAMEWIDTH-1:0] frame_count_q, frame_count_d;

   logic [4:0]    mem_q [FIFO_DEPTH];
   logic [4:0]    mem_d [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          pix_valid_q, pix_valid_d;
   logic [3:0]    pix_data_q, pix_data_d;
   logic          pix_last_q, pix_last_d;

   logic          push;
   logic          pop;
   logic [4:0]    push_data;
   logic [CW-1:0] count_after;
   logic [4:0]    head_next;

   // A result lands on the first cycle the engine drops busy.
   assign push        = (state_q == ST_WAIT_DONE) && !eng_running;
   assign pop         = pix_valid_q && pix.pix_ready;
   assign push_data   = {eng_finished, eng_ctr_out};
   assign count_after = count_q + CW'(push) - CW'(pop);

   assign eng_run       = (state_q == ST_ISSUE);
   assign eng_scaling   = eng_scaling_q;
   assign eng_cr_offset = eng_cr_offset_q;
   assign eng_ci_offset = eng_ci_offset_q;
   assign frame_count   = frame_count_q;
   assign pix.pix_valid = pix_valid_q;
   assign pix.pix_data  = pix_data_q;
   assign pix.pix_last  = pix_last_q;

   // Sequencer next-state, frame counter and engine configuration.
   always_comb begin
      state_d         = state_q;
      eng_scaling_d   = eng_scaling_q;
      eng_cr_offset_d = eng_cr_offset_q;
      eng_ci_offset_d = eng_ci_offset_q;
      frame_count_d   = frame_count_q;
      unique case (state_q)
         ST_IDLE: begin
            if (eng_finished) begin
               eng_scaling_d   = base_scaling;
               eng_cr_offset_d = base_cr;
               eng_ci_offset_d = base_ci;
            end
            if (enable && (count_q < DEPTH_C) && !eng_running) state_d = ST_ISSUE;
         end
         ST_ISSUE: state_d = ST_WAIT_START;
         ST_WAIT_START: begin
            if (eng_running) state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (!eng_running) begin
               if (eng_finished)                             state_d = ST_FRAME_END;
               else if (enable && (count_after < DEPTH_C))   state_d = ST_ISSUE;
               else                                          state_d = ST_IDLE;
            end
         end
         ST_FRAME_END: begin
            frame_count_d = frame_count_q + 1'b1;
            if (auto_zoom) begin
               if (eng_scaling_q != 7'd0) begin
                  eng_scaling_d   = eng_scaling_q - 7'd1;
                  eng_cr_offset_d = eng_cr_offset_q + cr_step;
                  eng_ci_offset_d = eng_ci_offset_q + ci_step;
               end else begin
                  eng_scaling_d   = base_scaling;
                  eng_cr_offset_d = base_cr;
                  eng_ci_offset_d = base_ci;
               end
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Result FIFO with registered head; head holds its last value when empty.
   always_comb begin
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_after;
      pix_data_d  = pix_data_q;
      pix_last_d  = pix_last_q;
      head_next   = mem_q[rd_ptr_q];
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      // A push into the slot that becomes the head bypasses the array.
      if (push && (wr_ptr_q == rd_ptr_d)) head_next = push_data;
      else                                head_next = mem_q[rd_ptr_d];
      pix_valid_d = (count_d != '0);
      if (count_d != '0) begin
         pix_data_d = head_next[3:0];
         pix_last_d = head_next[4];
      end
   end

   // Sequencer state, frame counter and FIFO registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         frame_count_q <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         pix_valid_q   <= 1'b0;
         pix_data_q    <= 4'd0;
         pix_last_q    <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 5'd0;
      end else begin
         state_q       <= state_d;
         frame_count_q <= frame_count_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         pix_valid_q   <= pix_valid_d;
         pix_data_q    <= pix_data_d;
         pix_last_q    <= pix_last_d;
         mem_q         <= mem_d;
      end
   end

   // Engine configuration follows the base inputs while reset is held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eng_scaling_q   <= base_scaling;
         eng_cr_offset_q <= base_cr;
         eng_ci_offset_q <= base_ci;
      end else begin
         eng_scaling_q   <= eng_scaling_d;
         eng_cr_offset_q <= eng_cr_offset_d;
         eng_ci_offset_q <= eng_ci_offset_d;
      end
   end

endmodule

// File: tb/tb_mandelbrot_frame_ctrl.sv
// Directed bench for mandelbrot_frame_ctrl with a small behavioural engine:
// 6 pixels per frame, 3 busy cycles per pixel, counter values 0..15 cyclic.
module tb_mandelbrot_frame_ctrl;

   localparam int BW        = 10;
   localparam int FRAME_PIX = 6;
   localparam int ITER      = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic          auto_zoom = 1'b1;
   logic [6:0]    base_scaling = 7'd5;
   logic [BW-1:0] base_cr = 10'h3C0;
   logic [BW-1:0] base_ci = 10'h380;
   logic [BW-1:0] cr_step = 10'h004;
   logic [BW-1:0] ci_step = 10'h3FC;
   logic          eng_run;
   logic          eng_running;
   logic          fin_q;
   logic          force_fin = 1'b0;
   logic          eng_finished;
   logic [3:0]    eng_ctr_out;
   logic [6:0]    eng_scaling;
   logic [BW-1:0] eng_cr_offset;
   logic [BW-1:0] eng_ci_offset;
   logic [7:0]    frame_count;

   int checks = 0;
   int failures = 0;
   int run_cnt = 0;
   int viol = 0;
   int run0;
   logic [4:0] got_q [$];

   mandelbrot_frame_ctrl_if pif ();

   assign eng_finished = fin_q | force_fin;

   mandelbrot_frame_ctrl #(.BITWIDTH(BW), .FIFO_DEPTH(8), .FRAMEWIDTH(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .auto_zoom     (auto_zoom),
      .base_scaling  (base_scaling),
      .base_cr       (base_cr),
      .base_ci       (base_ci),
      .cr_step       (cr_step),
      .ci_step       (ci_step),
      .eng_run       (eng_run),
      .eng_running   (eng_running),
      .eng_finished  (eng_finished),
      .eng_ctr_out   (eng_ctr_out),
      .eng_scaling   (eng_scaling),
      .eng_cr_offset (eng_cr_offset),
      .eng_ci_offset (eng_ci_offset),
      .pix           (pif.master),
      .frame_count   (frame_count)
   );

   always #5 clk = ~clk;

   // Behavioural engine.
   int         busy_cnt;
   int         pix_idx;
   logic [3:0] ctr_next;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eng_running <= 1'b0;
         fin_q       <= 1'b0;
         eng_ctr_out <= 4'd0;
         busy_cnt    <= 0;
         pix_idx     <= 0;
         ctr_next    <= 4'd0;
      end else if (eng_run && !eng_running) begin
         eng_running <= 1'b1;
         busy_cnt    <= ITER - 1;
         fin_q       <= 1'b0;
      end else if (eng_running) begin
         if (busy_cnt == 0) begin
            eng_running <= 1'b0;
            eng_ctr_out <= ctr_next;
            ctr_next    <= ctr_next + 4'd1;
            fin_q       <= (pix_idx == FRAME_PIX - 1);
            pix_idx     <= (pix_idx == FRAME_PIX - 1) ? 0 : pix_idx + 1;
         end else begin
            busy_cnt <= busy_cnt - 1;
         end
      end else begin
         fin_q <= 1'b0;
      end
   end

   // Stream and run-pulse monitor.
   always @(negedge clk) begin
      if (rst_n) begin
         if (pif.pix_valid && pif.pix_ready) got_q.push_back({pif.pix_last, pif.pix_data});
         if (eng_run) run_cnt++;
         if (eng_run && eng_running) viol++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_frames(input logic [7:0] target);
      int i;
      i = 0;
      while (frame_count != target && i < 600) begin
         @(posedge clk);
         #1;
         i++;
      end
   endtask

   task automatic chk_cfg(input string tag, input logic [6:0] s, input logic [BW-1:0] cr,
                          input logic [BW-1:0] ci);
      chk({tag, "_scaling"}, 32'(eng_scaling), 32'(s));
      chk({tag, "_cr"}, 32'(eng_cr_offset), 32'(cr));
      chk({tag, "_ci"}, 32'(eng_ci_offset), 32'(ci));
   endtask

   function automatic logic [31:0] q_at(input int i);
      return (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF;
   endfunction

   initial begin
      int i;
      pif.pix_ready = 1'b0;

      // Reset values
      step(3);
      chk_cfg("rst", 7'd5, 10'h3C0, 10'h380);
      chk("rst_valid", 32'(pif.pix_valid), 0);
      chk("rst_data", 32'(pif.pix_data), 0);
      chk("rst_last", 32'(pif.pix_last), 0);
      chk("rst_frame", 32'(frame_count), 0);
      chk("rst_run", 32'(eng_run), 0);

      // First frame streamed with consumer always ready; zoom applied at end
      rst_n = 1'b1;
      enable = 1'b1;
      pif.pix_ready = 1'b1;
      wait_frames(8'd1);
      enable = 1'b0;
      chk("f1_frame", 32'(frame_count), 1);
      chk("f1_runs", 32'(run_cnt), 6);
      chk("f1_qlen", 32'(got_q.size()), 6);
      for (int k = 0; k < 6; k++) chk($sformatf("f1_pix%0d", k), q_at(k), 32'((k == 5) ? 5'h10 + k : k));
      chk_cfg("f1", 7'd4, 10'h3C4, 10'h37C);
      step(3);
      chk("f1_norun", 32'(run_cnt), 6);

      // Back-pressure: FIFO fills with 8 pixels, crossing a frame boundary
      got_q.delete();
      pif.pix_ready = 1'b0;
      enable = 1'b1;
      run0 = run_cnt;
      step(100);
      chk("full_runs", 32'(run_cnt - run0), 8);
      chk("full_valid", 32'(pif.pix_valid), 1);
      chk("full_head", 32'(pif.pix_data), 6);
      chk("full_frame", 32'(frame_count), 2);
      chk_cfg("f2", 7'd3, 10'h3C8, 10'h378);
      pif.pix_ready = 1'b1;
      step(1);
      pif.pix_ready = 1'b0;
      step(50);
      chk("pulse_runs", 32'(run_cnt - run0), 9);
      chk("pulse_head", 32'(pif.pix_data), 7);
      enable = 1'b0;
      pif.pix_ready = 1'b1;
      step(15);
      chk("drain_qlen", 32'(got_q.size()), 9);
      for (int k = 0; k < 9; k++)
         chk($sformatf("drain_pix%0d", k), q_at(k), 32'((k + 6 == 11) ? 5'h1B : k + 6));
      chk("drain_valid", 32'(pif.pix_valid), 0);

      // Pause mid-pixel, then resume the same frame
      got_q.delete();
      enable = 1'b1;
      run0 = run_cnt;
      i = 0;
      while (!eng_running && i < 20) begin
         step(1);
         i++;
      end
      enable = 1'b0;
      step(20);
      chk("pause_runs", 32'(run_cnt - run0), 1);
      chk("pause_qlen", 32'(got_q.size()), 1);
      chk("pause_pix", q_at(0), 15);
      chk("pause_valid", 32'(pif.pix_valid), 0);
      chk_cfg("pause", 7'd3, 10'h3C8, 10'h378);
      enable = 1'b1;
      wait_frames(8'd3);
      enable = 1'b0;
      chk("resume_qlen", 32'(got_q.size()), 3);
      chk("resume_pix1", q_at(1), 0);
      chk("resume_pix2", q_at(2), 32'h11);
      chk_cfg("f3", 7'd2, 10'h3CC, 10'h374);

      // Zoom down to scaling 0, then wrap reloads the current base values
      enable = 1'b1;
      wait_frames(8'd5);
      enable = 1'b0;
      chk_cfg("f5", 7'd0, 10'h3D4, 10'h36C);
      base_scaling = 7'd2;
      base_cr = 10'h010;
      base_ci = 10'h020;
      enable = 1'b1;
      wait_frames(8'd6);
      enable = 1'b0;
      chk("f6_frame", 32'(frame_count), 6);
      chk_cfg("wrap", 7'd2, 10'h010, 10'h020);

      // Auto-zoom off holds configuration across a frame
      auto_zoom = 1'b0;
      enable = 1'b1;
      wait_frames(8'd7);
      enable = 1'b0;
      chk("f7_frame", 32'(frame_count), 7);
      chk_cfg("hold", 7'd2, 10'h010, 10'h020);

      // IDLE reload happens only while the engine reports finished
      base_scaling = 7'h55;
      base_cr = 10'h2AA;
      base_ci = 10'h155;
      step(3);
      chk_cfg("idle_nofin", 7'd2, 10'h010, 10'h020);
      force_fin = 1'b1;
      step(1);
      force_fin = 1'b0;
      step(1);
      chk_cfg("idle_fin", 7'h55, 10'h2AA, 10'h155);

      // Asynchronous reset in the middle of a frame
      pif.pix_ready = 1'b0;
      enable = 1'b1;
      i = 0;
      while (!pif.pix_valid && i < 40) begin
         step(1);
         i++;
      end
      chk("pre_rst_valid", 32'(pif.pix_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(pif.pix_valid), 0);
      chk("arst_frame", 32'(frame_count), 0);
      chk("arst_run", 32'(eng_run), 0);
      chk_cfg("arst", 7'h55, 10'h2AA, 10'h155);
      chk("no_run_while_busy", 32'(viol), 0);
      step(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
